// File: rtl/vc_arb_pkg.sv
// Shared types and sizing helpers for the VC send arbiter.
package vc_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int STATS_WIDTH = 32;

  // Counter must hold every value 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr, wrapping upward.
module rr_arbiter
  import vc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_send_arbiter.sv
// Shares one router injection port among NUM_REQ bundles with per-VC credits and wormhole locking.
// Optional stall counter port enabled by defining VC_SEND_ARB_STATS_EN.
module vc_send_arbiter
  import vc_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int N_ADDR_WIDTH  = 4,
  parameter int VC_ADDR_WIDTH = 2,
  parameter int WIDTH_DATA    = 32,
  parameter int VC_DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_last,
  input  logic [NUM_REQ*WIDTH_DATA-1:0]     req_data,
  input  logic [NUM_REQ*N_ADDR_WIDTH-1:0]   req_dest,
  input  logic [NUM_REQ*VC_ADDR_WIDTH-1:0]  req_vc,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              out_valid,
  output logic [WIDTH_DATA-1:0]             out_data,
  output logic [N_ADDR_WIDTH-1:0]           out_dest,
  output logic [VC_ADDR_WIDTH-1:0]          out_vc,
  output logic                              out_last,
  input  logic                              credit_valid,
  input  logic [VC_ADDR_WIDTH-1:0]          credit_vc,
`ifdef VC_SEND_ARB_STATS_EN
  output logic [STATS_WIDTH-1:0]            stall_cycles,
`endif
  output logic                              credit_err
);

  localparam int              NUM_VC      = 1 << VC_ADDR_WIDTH;
  localparam int              CW          = credit_width(VC_DEPTH);
  localparam int              PTR_W       = ptr_width(NUM_REQ);
  localparam logic [CW-1:0]   CREDIT_FULL = CW'(VC_DEPTH);

  arb_state_e               state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [PTR_W-1:0]         owner_q, owner_d;
  logic [VC_ADDR_WIDTH-1:0] lock_vc_q, lock_vc_d;
  logic [CW-1:0]            credit_q [NUM_VC];
  logic [CW-1:0]            credit_d [NUM_VC];
  logic                     credit_err_q, credit_err_d;

  logic                     out_valid_q, out_valid_d;
  logic [WIDTH_DATA-1:0]    out_data_q, out_data_d;
  logic [N_ADDR_WIDTH-1:0]  out_dest_q, out_dest_d;
  logic [VC_ADDR_WIDTH-1:0] out_vc_q, out_vc_d;
  logic                     out_last_q, out_last_d;

  logic [VC_ADDR_WIDTH-1:0] vc_a   [NUM_REQ];
  logic [WIDTH_DATA-1:0]    data_a [NUM_REQ];
  logic [N_ADDR_WIDTH-1:0]  dest_a [NUM_REQ];
  logic [NUM_REQ-1:0]       eligible, rr_grant, grant_vec;
  logic                     accept;
  logic [PTR_W-1:0]         sel_idx;
  logic [VC_ADDR_WIDTH-1:0] sel_vc;
  logic [NUM_VC-1:0]        credit_inc, credit_dec;

  always_comb begin : unpack_requests
    for (int i = 0; i < NUM_REQ; i++) begin
      vc_a[i]     = req_vc[i*VC_ADDR_WIDTH +: VC_ADDR_WIDTH];
      data_a[i]   = req_data[i*WIDTH_DATA +: WIDTH_DATA];
      dest_a[i]   = req_dest[i*N_ADDR_WIDTH +: N_ADDR_WIDTH];
      eligible[i] = req_valid[i] && (credit_q[vc_a[i]] != '0);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (rr_grant)
  );

  always_comb begin : arb_fsm
    grant_vec = '0;
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    lock_vc_d = lock_vc_q;
    sel_idx   = '0;

    case (state_q)
      ARB_IDLE:   grant_vec = rr_grant;
      ARB_LOCKED: grant_vec[owner_q] = req_valid[owner_q] && (credit_q[lock_vc_q] != '0);
      default:    grant_vec = '0;
    endcase
    if (rst) grant_vec = '0;

    accept = |grant_vec;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vec[i]) sel_idx = PTR_W'(i);
    end
    // Body flits travel on the VC chosen for the head, whatever the shim says now.
    sel_vc = (state_q == ARB_LOCKED) ? lock_vc_q : vc_a[sel_idx];

    if (accept) begin
      if (!req_last[sel_idx]) begin
        state_d   = ARB_LOCKED;
        owner_d   = sel_idx;
        lock_vc_d = sel_vc;
      end else begin
        state_d = ARB_IDLE;
        ptr_d   = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
      end
    end
  end

  always_comb begin : credit_next
    credit_err_d = credit_err_q;
    credit_inc   = '0;
    credit_dec   = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      credit_d[v]   = credit_q[v];
      credit_inc[v] = credit_valid && (credit_vc == VC_ADDR_WIDTH'(v));
      credit_dec[v] = accept && (sel_vc == VC_ADDR_WIDTH'(v));
      if (credit_inc[v] && !credit_dec[v]) begin
        if (credit_q[v] == CREDIT_FULL) credit_err_d = 1'b1;
        else                            credit_d[v]  = credit_q[v] + CW'(1);
      end else if (credit_dec[v] && !credit_inc[v]) begin
        credit_d[v] = credit_q[v] - CW'(1);
      end
    end
  end

  always_comb begin : out_next
    out_valid_d = accept;
    out_data_d  = accept ? data_a[sel_idx]   : out_data_q;
    out_dest_d  = accept ? dest_a[sel_idx]   : out_dest_q;
    out_vc_d    = accept ? sel_vc            : out_vc_q;
    out_last_d  = accept ? req_last[sel_idx] : out_last_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      lock_vc_q    <= '0;
      credit_err_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_dest_q   <= '0;
      out_vc_q     <= '0;
      out_last_q   <= 1'b0;
      // NOTE: the credit array is a handful of flops, not RAM, so it is reset to refill the window.
      for (int v = 0; v < NUM_VC; v++) credit_q[v] <= CREDIT_FULL;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      lock_vc_q    <= lock_vc_d;
      credit_err_q <= credit_err_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_dest_q   <= out_dest_d;
      out_vc_q     <= out_vc_d;
      out_last_q   <= out_last_d;
      for (int v = 0; v < NUM_VC; v++) credit_q[v] <= credit_d[v];
    end
  end

`ifdef VC_SEND_ARB_STATS_EN
  logic [STATS_WIDTH-1:0] stall_q, stall_d;

  always_comb begin : stall_next
    stall_d = stall_q;
    if ((|req_valid) && !accept && (stall_q != '1)) stall_d = stall_q + STATS_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

  assign req_ready  = grant_vec;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_dest   = out_dest_q;
  assign out_vc     = out_vc_q;
  assign out_last   = out_last_q;
  assign credit_err = credit_err_q;

endmodule

// File: doc/vc_send_arbiter.md
Name: vc_send_arbiter

Overview:
- Shares one NoC router injection port between NUM_REQ sending bundles.
- Each bundle supplies its flit, destination and VC. The VC comes from that bundle's VC lookup shim.
- Per-VC credit counters track downstream buffer space. Arbitration is round-robin with wormhole packet locking: once granted, a requester keeps the port until its tail flit.
- Sits between the bundles' VC shims and the router's flit/credit interface.

Parameters:
NUM_REQ, 4, number of sending bundles (>=1)
N_ADDR_WIDTH, 4, router address width
VC_ADDR_WIDTH, 2, VC address width; NUM_VC = 2**VC_ADDR_WIDTH
WIDTH_DATA, 32, flit payload width
VC_DEPTH, 4, downstream buffer depth per VC; initial and maximum credit count

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  bundle i has a flit
req_last  in  NUM_REQ  flit i is a packet tail
req_data  in  NUM_REQ*WIDTH_DATA  flit payload, bundle i in slice i
req_dest  in  NUM_REQ*N_ADDR_WIDTH  destination router
req_vc  in  NUM_REQ*VC_ADDR_WIDTH  VC from bundle i's VC shim
req_ready  out  NUM_REQ  one-hot or zero; flit i is accepted this cycle
out_valid  out  1  registered flit valid to router
out_data  out  WIDTH_DATA  flit payload
out_dest  out  N_ADDR_WIDTH  destination
out_vc  out  VC_ADDR_WIDTH  VC of flit
out_last  out  1  tail marker
credit_valid  in  1  router returns one credit
credit_vc  in  VC_ADDR_WIDTH  VC of the returned credit
credit_err  out  1  sticky; a credit was returned to a full counter

Behaviour:
- Reset values:
  - all out_* = 0, req_ready = 0, credit_err = 0.
  - every credit counter = VC_DEPTH.
  - round-robin pointer = 0; FSM in IDLE.
- FSM state IDLE:
  - Eligible requester: req_valid[i]=1 and credit[req_vc[i]] > 0.
  - Winner: first eligible index at or after the pointer, searching upward and wrapping.
  - Winner gets req_ready[i]=1 in the same cycle (combinational). The flit is transferred.
  - If req_last=0: go to LOCKED(owner=i).
  - If req_last=1: stay in IDLE; pointer = i+1 mod NUM_REQ.
- FSM state LOCKED(owner):
  - Only the owner is considered. VC is latched from the head flit; req_vc is ignored until the tail.
  - req_ready[owner] = req_valid[owner] && credit[locked_vc] > 0.
  - Tail flit accepted: go to IDLE; pointer = owner+1 mod NUM_REQ.
  - Other requesters see ready=0 even if their VC has credit.
- Handshake: a flit transfers when req_valid[i] && req_ready[i]. req_ready never rises without valid.
- Output latency:
  - out_* registered: a flit accepted in cycle t appears on out_* in cycle t+1 for exactly one cycle.
  - out_valid = 0 in cycles with no acceptance; out_data etc. hold their last value.
  - No backpressure on out; credits guarantee space.
- Credit rules:
  - A transfer decrements credit[vc].
  - credit_valid increments credit[credit_vc].
  - Same VC, same cycle: net unchanged.
  - Return to a counter already at VC_DEPTH: counter saturates, credit_err latches 1 until rst.
  - Counter width = $clog2(VC_DEPTH+1).
  - A credit returned in cycle t is usable for a grant in cycle t+1.
- NUM_REQ=1: arbiter degenerates; pointer stays 0.
- rst mid-packet: FSM returns to IDLE and credits refill to VC_DEPTH. The partial packet is abandoned; the upstream system is responsible.

Optional Feature:
- Macro VC_SEND_ARB_STATS_EN.
- Defined:
  - Adds output stall_cycles[31:0], reset 0.
  - Increments each cycle where any req_valid=1 but no flit is accepted.
  - Saturates at all-ones.
- Undefined: port and counter are absent; no other behavioural change.

Decomposition:
- Package vc_arb_pkg:
  - state enum {ARB_IDLE, ARB_LOCKED}.
  - credit-width helper function.
  - localparam STATS_WIDTH=32.
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: request vector, pointer.
  - output: one-hot grant, combinational.
  - Instantiated once; FSM, credits and output register live in vc_send_arbiter.

Test Plan:
- Single packet: req0 valid, vc=1, 3 flits, last on the 3rd → out_valid 3 consecutive cycles starting 1 cycle after acceptance; credit[1] goes 4→1.
- Fairness: req0..3 all valid, distinct VCs, single-flit packets, ample credits → grant order 0,1,2,3,0.
- Lock: req1 sends a 4-flit packet while req2 is valid → req2 ready=0 until req1's tail is accepted; req2 wins the next cycle.
- Credit starvation: VC_DEPTH=4, 5 single-flit packets on vc=0, no credits returned → 4 accepted, 5th held. credit_valid, credit_vc=0 at cycle t → 5th flit accepted at cycle t+1.
- Simultaneous credit return and consume on the same VC → counter unchanged. Extra return at 4 → counter stays 4, credit_err=1 persists until rst.
- Reset mid-packet: rst while LOCKED → next cycle IDLE, all credits 4, out_valid=0. With STATS_EN, stall_cycles=0.
